// File: rtl/cp0_eret_redirect.sv
// Exception/ERET redirect issuer: captures WB-stage commits, holds the fetch
// redirect target until fetch accepts it, and emits flush / EXL strobes.
module cp0_eret_redirect #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [5:0]  EPC_ADDR   = 6'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic        eret,
  input  logic [31:0] cp0_EPC_data,
  input  logic        mtc0_we,
  input  logic [5:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  input  logic        fetch_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        busy
);

  typedef enum logic {IDLE, REDIR} state_t;

  state_t      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;
  logic        exl_set_q, exl_set_d;
  logic        exl_clr_q, exl_clr_d;

  logic        eret_acc;
  logic        transfer;
  logic        epc_fwd;
  logic [31:0] eret_target;

  // An ERET racing an mtc0 to EPC must return to the value being written now.
  assign epc_fwd     = mtc0_we && (cp0_addr == EPC_ADDR);
  assign eret_target = epc_fwd ? mtc0_data : cp0_EPC_data;

  assign eret_acc = eret && !exception && (state_q == IDLE);
  assign transfer = (state_q == REDIR) && fetch_ready;

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;
    exl_set_d     = 1'b0;
    exl_clr_d     = 1'b0;
    if (exception) begin
      // Wins over both a concurrent ERET and a concurrent transfer.
      state_d       = REDIR;
      redirect_pc_d = EXC_VECTOR;
      flush_d       = 1'b1;
      exl_set_d     = 1'b1;
    end else if (eret_acc) begin
      state_d       = REDIR;
      redirect_pc_d = eret_target;
      flush_d       = 1'b1;
      exl_clr_d     = 1'b1;
    end else if (transfer) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      redirect_pc_q <= 32'h0;
      flush_q       <= 1'b0;
      exl_set_q     <= 1'b0;
      exl_clr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      exl_set_q     <= exl_set_d;
      exl_clr_q     <= exl_clr_d;
    end
  end

  assign redirect_valid = (state_q == REDIR);
  assign busy           = (state_q == REDIR);
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign exl_set        = exl_set_q;
  assign exl_clr        = exl_clr_q;

endmodule

// File: tb/tb_cp0_eret_redirect.sv
// Bench for cp0_eret_redirect: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against a behavioural model.
module tb_cp0_eret_redirect;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst, exception, eret, mtc0_we, fetch_ready;
  logic [31:0] cp0_EPC_data, mtc0_data;
  logic [5:0]  cp0_addr;
  logic        redirect_valid, flush, exl_set, exl_clr, busy;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  // model state: what the outputs must read after the most recent edge
  logic        m_valid, m_flush, m_set, m_clr;
  logic [31:0] m_pc;
  int          m_transfers = 0;

  cp0_eret_redirect dut (
    .clk(clk), .rst(rst), .exception(exception), .eret(eret),
    .cp0_EPC_data(cp0_EPC_data), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
    .mtc0_data(mtc0_data), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .exl_set(exl_set), .exl_clr(exl_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge and apply the rules to the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_pc = 32'h0; m_flush = 0; m_set = 0; m_clr = 0;
    end else begin
      logic was_pending;
      was_pending = m_valid;
      if (was_pending && fetch_ready) m_transfers++;
      m_flush = 0; m_set = 0; m_clr = 0;
      if (exception) begin
        m_valid = 1; m_pc = EXC_VEC; m_flush = 1; m_set = 1;
      end else if (eret && !was_pending) begin
        m_valid = 1;
        m_pc = (mtc0_we && cp0_addr == 6'd14) ? mtc0_data : cp0_EPC_data;
        m_flush = 1; m_clr = 1;
      end else if (was_pending && fetch_ready) begin
        m_valid = 0;
      end
    end
    started = 1;
    #1;
  endtask

  task automatic idle_inputs();
    exception = 0; eret = 0; mtc0_we = 0; cp0_addr = 6'd0; mtc0_data = 32'h0;
  endtask

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_valid});
      check("busy",           {31'b0, busy},           {31'b0, m_valid});
      check("redirect_pc",    redirect_pc,             m_pc);
      check("flush",          {31'b0, flush},          {31'b0, m_flush});
      check("exl_set",        {31'b0, exl_set},        {31'b0, m_set});
      check("exl_clr",        {31'b0, exl_clr},        {31'b0, m_clr});
    end
  end

  initial begin
    int t0;
    rst = 1; exception = 1; eret = 0; mtc0_we = 0; cp0_addr = 0; mtc0_data = 0;
    cp0_EPC_data = 32'h0; fetch_ready = 0;
    m_valid = 0; m_pc = 0; m_flush = 0; m_set = 0; m_clr = 0;

    // Reset with exception held: the exception is lost.
    repeat (3) tick();
    rst = 0; exception = 0;
    tick();
    check("rst_valid", {31'b0, redirect_valid}, 32'd0);
    check("rst_pc", redirect_pc, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'd0);

    // Plain ERET with fetch ready.
    cp0_EPC_data = 32'h8000_1234; eret = 1; fetch_ready = 1;
    tick();
    eret = 0;
    check("eret_valid", {31'b0, redirect_valid}, 32'd1);
    check("eret_pc", redirect_pc, 32'h8000_1234);
    check("eret_flush", {31'b0, flush}, 32'd1);
    check("eret_clr", {31'b0, exl_clr}, 32'd1);
    tick();
    check("eret_done", {31'b0, redirect_valid}, 32'd0);

    // Same-cycle mtc0 to EPC is forwarded.
    cp0_EPC_data = 32'h0; eret = 1; mtc0_we = 1; cp0_addr = 6'd14;
    mtc0_data = 32'hBFC0_2000; fetch_ready = 0;
    tick();
    idle_inputs();
    check("fwd_pc", redirect_pc, 32'hBFC0_2000);
    fetch_ready = 1; tick(); fetch_ready = 0;

    // Simultaneous exception and ERET.
    exception = 1; eret = 1;
    tick();
    idle_inputs();
    check("both_pc", redirect_pc, EXC_VEC);
    check("both_set", {31'b0, exl_set}, 32'd1);
    check("both_clr", {31'b0, exl_clr}, 32'd0);
    tick();
    check("both_single_flush", {31'b0, flush}, 32'd0);
    fetch_ready = 1; tick(); fetch_ready = 0;

    // Backpressure; a second ERET during the stall is ignored.
    cp0_EPC_data = 32'h1111_2220; eret = 1;
    tick();
    check("bp_flush0", {31'b0, flush}, 32'd1);
    cp0_EPC_data = 32'h3333_4440;
    tick();
    eret = 0;
    check("bp_pc_hold", redirect_pc, 32'h1111_2220);
    check("bp_no_clr", {31'b0, exl_clr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {31'b0, redirect_valid}, 32'd1);
      check("bp_flush", {31'b0, flush}, 32'd0);
    end

    // Exception while the redirect is stalled overwrites the target.
    exception = 1;
    tick();
    exception = 0;
    check("xr_pc", redirect_pc, EXC_VEC);
    check("xr_flush", {31'b0, flush}, 32'd1);
    check("xr_set", {31'b0, exl_set}, 32'd1);
    tick();
    t0 = m_transfers;
    fetch_ready = 1;
    tick();
    check("xr_idle", {31'b0, redirect_valid}, 32'd0);
    tick();
    check("xr_one_transfer", m_transfers - t0, 32'd1);
    fetch_ready = 0;

    // Exception coinciding with a transfer reloads the vector.
    cp0_EPC_data = 32'h0000_4000; eret = 1; tick(); eret = 0;
    exception = 1; fetch_ready = 1; tick(); exception = 0;
    check("xt_valid", {31'b0, redirect_valid}, 32'd1);
    check("xt_pc", redirect_pc, EXC_VEC);
    tick(); fetch_ready = 0;

    // Reset mid-redirect discards it.
    eret = 1; tick(); eret = 0;
    rst = 1; tick(); rst = 0;
    check("rst_mid_valid", {31'b0, redirect_valid}, 32'd0);
    check("rst_mid_pc", redirect_pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      exception    = ($urandom_range(0, 9) == 0);
      eret         = ($urandom_range(0, 4) == 0);
      mtc0_we      = ($urandom_range(0, 2) == 0);
      cp0_addr     = ($urandom_range(0, 1) == 0) ? 6'd14 : 6'($urandom_range(0, 31));
      mtc0_data    = $urandom;
      cp0_EPC_data = $urandom;
      fetch_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 0; idle_inputs();
    tick();

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
